// File: rtl/rv_timer.sv
// rv_timer: memory-mapped timer/compare peripheral with prescaler and match interrupt.
// Optional 64-bit free-running cycle counter with coherent LO/HI reads is enabled
// by defining the macro RV_TIMER_CYCLE_EN.
module rv_timer #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic        irq
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_COUNT  = 3'd1;
  localparam logic [2:0] A_CMP    = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
`ifdef RV_TIMER_CYCLE_EN
  localparam logic [2:0] A_CYC_LO = 3'd4;
  localparam logic [2:0] A_CYC_HI = 3'd5;
`endif

  // Control fields
  logic             r_en;
  logic             r_ar;
  logic             r_ie;
  logic [PRE_W-1:0] r_pre;
  // Timer state
  logic [PRE_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_compare;
  logic             r_mf;
  logic [31:0]      r_dr;

  logic [2:0]       w_sel;
  logic             w_acc;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_bmask;
  logic             w_ctrl_wr;
  logic             w_cnt_wr;
  logic             w_cmp_wr;
  logic             w_st_wr;
  logic             w_tick;
  logic             w_match;
  logic             w_mf_clr;
  logic [31:0]      w_ctrl_rd;
  logic [31:0]      w_cnt_rd;
  logic [31:0]      w_cmp_rd;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Byte offsets inside a word are never decoded.
  assign w_unused  = &{1'b0, adr[1:0]};

  assign w_sel     = adr[4:2];
  assign w_acc     = cs & rdy;
  assign w_wr      = w_acc & (we != 4'b0000);
  assign w_rd      = w_acc & re;
  assign w_bmask   = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign w_ctrl_wr = w_wr & (w_sel == A_CTRL);
  assign w_cnt_wr  = w_wr & (w_sel == A_COUNT);
  assign w_cmp_wr  = w_wr & (w_sel == A_CMP);
  assign w_st_wr   = w_wr & (w_sel == A_STATUS);

  // A tick fires on the cycle the prescaler reaches PRE; a COUNT write swallows it.
  assign w_tick    = r_en & (r_pcnt == r_pre);
  assign w_match   = w_tick & ~w_cnt_wr & (r_count == r_compare);
  assign w_mf_clr  = w_st_wr & we[0] & dw[0];

  // Both operands are flops, so no bus input reaches irq combinationally.
  assign irq = r_mf & r_ie;
  assign dr  = r_dr;

  // Assemble zero-extended register images for readback.
  always_comb begin
    w_ctrl_rd                = '0;
    w_ctrl_rd[0]             = r_en;
    w_ctrl_rd[1]             = r_ar;
    w_ctrl_rd[2]             = r_ie;
    w_ctrl_rd[8 +: PRE_W]    = r_pre;
    w_cnt_rd                 = '0;
    w_cnt_rd[CNT_W-1:0]      = r_count;
    w_cmp_rd                 = '0;
    w_cmp_rd[CNT_W-1:0]      = r_compare;
  end

`ifdef RV_TIMER_CYCLE_EN
  logic [63:0] r_cyc;
  logic [31:0] r_cyc_hi;

  // Free-running cycle counter; a LO read snapshots the high word for a coherent HI read.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_cyc    <= '0;
      r_cyc_hi <= '0;
    end else begin
      r_cyc <= r_cyc + 64'd1;
      if (w_rd && (w_sel == A_CYC_LO)) r_cyc_hi <= r_cyc[63:32];
    end
  end
`endif

  // Read mux; reserved offsets (and cycle offsets when not built in) return zero.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      A_CTRL:   w_rdata = w_ctrl_rd;
      A_COUNT:  w_rdata = w_cnt_rd;
      A_CMP:    w_rdata = w_cmp_rd;
      A_STATUS: w_rdata = {31'd0, r_mf};
`ifdef RV_TIMER_CYCLE_EN
      A_CYC_LO: w_rdata = r_cyc[31:0];
      A_CYC_HI: w_rdata = r_cyc_hi;
`endif
      default:  w_rdata = '0;
    endcase
  end

  // Control register with byte-lane write enables.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_en  <= 1'b0;
      r_ar  <= 1'b0;
      r_ie  <= 1'b0;
      r_pre <= '0;
    end else if (w_ctrl_wr) begin
      if (we[0]) begin
        r_en <= dw[0];
        r_ar <= dw[1];
        r_ie <= dw[2];
      end
      r_pre <= (r_pre & ~w_bmask[8 +: PRE_W]) | (dw[8 +: PRE_W] & w_bmask[8 +: PRE_W]);
    end
  end

  // Prescaler: restarts on any COUNT write, idles at zero while disabled.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_pcnt <= '0;
    end else if (w_cnt_wr || !r_en || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRE_W'(1);
    end
  end

  // Counter: software write wins over a tick; match with auto-reload returns to zero.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_count <= '0;
    end else if (w_cnt_wr) begin
      r_count <= (r_count & ~w_bmask[CNT_W-1:0]) | (dw[CNT_W-1:0] & w_bmask[CNT_W-1:0]);
    end else if (w_tick) begin
      if (w_match && r_ar) r_count <= '0;
      else                 r_count <= r_count + CNT_W'(1);
    end
  end

  // Compare register; resets to all ones so an idle timer does not match early.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_compare <= '1;
    end else if (w_cmp_wr) begin
      r_compare <= (r_compare & ~w_bmask[CNT_W-1:0]) | (dw[CNT_W-1:0] & w_bmask[CNT_W-1:0]);
    end
  end

  // Match flag: a match in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_mf <= 1'b0;
    end else if (w_match) begin
      r_mf <= 1'b1;
    end else if (w_mf_clr) begin
      r_mf <= 1'b0;
    end
  end

  // Registered read data, driven only in the cycle after an accepted read.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_dr <= '0;
    end else if (w_rd) begin
      r_dr <= w_rdata;
    end else begin
      r_dr <= '0;
    end
  end

endmodule

// File: doc/rv_timer.md
Name: rv_timer

Overview:
- Memory-mapped timer/compare peripheral.
- Acts as a responder on the CPU data bus (d_adr/d_re/d_we/d_dw/d_dr), at window ffff0080–ffff009f.
- Top level decodes cs = {d_adr[31:5],5'h0}==32'hffff0080 and ORs dr into the shared read-data bus.
- Raises a level interrupt on compare match, for periodic OS ticks and timeouts.

Parameters:
- CNT_W, 32: width of COUNT/COMPARE (1..32); reads zero-extended to 32 bits.
- PRE_W, 8: prescaler width; CTRL.PRE field is PRE_W bits at CTRL[8+PRE_W-1:8].

Ports:
- clk  input  1  bus/CPU clock.
- xreset  input  1  asynchronous active-low reset; all flops clear on assertion.
- adr  input  5  byte offset within window (only [4:2] decoded).
- cs  input  1  window select.
- rdy  input  1  bus ready; accesses are qualified by cs&rdy.
- we  input  4  byte write enables (we[i] -> dw[8i+7:8i]).
- re  input  1  read enable.
- dw  input  32  write data.
- dr  output  32  read data; registered; zero when not returning a read.
- irq  output  1  interrupt request, level, active-high.

Behaviour:
- Registers, by adr[4:2]:
  - 0 CTRL: [0] EN, [1] AR (auto-reload), [2] IE, [8+:PRE_W] PRE.
  - 1 COUNT (rw).
  - 2 COMPARE (rw).
  - 3 STATUS: [0] MF (match flag), write-1-to-clear.
  - 4 CYC_LO, 5 CYC_HI: see Optional Feature.
  - 6, 7: reserved, read 0, writes ignored.
- Write: when cs&rdy&(we!=0), bytes with we[i]=1 update; bits above the register width are ignored.
- Read latency: cs&rdy&re at cycle N -> dr valid at cycle N+1 (value of register at cycle N); dr=0 in every other cycle.
- Reset values: CTRL=0, COUNT=0, COMPARE=all ones, MF=0, dr=0, irq=0, prescaler=0.
- Prescaler:
  - pcnt counts clk cycles while EN=1.
  - tick asserted for one cycle when pcnt==PRE, then pcnt<=0; otherwise pcnt<=pcnt+1.
  - PRE=0 gives a tick every cycle.
  - EN=0 holds pcnt at 0 and generates no ticks.
- On tick:
  - If COUNT==COMPARE: MF<=1; COUNT<=0 if AR=1, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Increment wraps modulo 2^CNT_W (all ones -> 0) with no flag.
  - Period with AR=1 is (COMPARE+1)*(PRE+1) clk cycles.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick wins; the tick is dropped and pcnt<=0.
  - Any write to COUNT also clears pcnt.
  - Setting MF and a W1C clear of MF in the same cycle: set wins, MF=1.
  - A write to COMPARE takes effect from the next cycle's comparison.
- irq = MF & IE, both from flops; no combinational path from bus inputs to irq or dr.
- Clearing IE drops irq next cycle but MF is retained.
- Reset mid-operation: asynchronous clear of all state; no pending read data survives (dr=0 immediately).

Optional Feature:
- Macro RV_TIMER_CYCLE_EN.
- Defined:
  - 64-bit free-running cycle counter, +1 every clk from reset, independent of EN, wraps at 2^64.
  - Reading CYC_LO returns the low word and latches the high word into a shadow register in the same cycle.
  - Reading CYC_HI returns the shadow, giving a coherent 64-bit read when LO is read first.
  - Writes are ignored.
- Not defined: CYC_LO/CYC_HI read 0; no counter or shadow flops are synthesized.

Test Plan:
- Reset: after xreset release, read offsets 0x00, 0x04, 0x08, 0x0C -> 0, 0, ffffffff, 0 (each one cycle after re); irq=0; dr=0 on non-read cycles.
- Periodic with prescaler: COMPARE=4, CTRL=EN|AR|IE with PRE=2 -> MF/irq rise 15 clk after EN write, COUNT reads 0 afterwards; after W1C of STATUS=1, irq falls and re-rises 15 clk later.
- One-shot wrap: AR=0, PRE=0, COUNT=ffffffff written, COMPARE=5 -> next tick COUNT=0 with MF=0, MF=1 after COUNT passes 5, COUNT continues to 7.
- Collisions: write COUNT=100 in a tick cycle -> COUNT reads 100, not 101; W1C of MF coincident with a match -> MF stays 1.
- Byte writes: we=4'b0010, dw=0000_AB00 to COMPARE (ffffffff) -> COMPARE=ffffabff; IE=0 with MF=1 -> irq=0.
- RV_TIMER_CYCLE_EN: preload the counter near 0x0000_0000_ffff_fffe via a forced value; read LO then HI across the carry -> HI consistent with LO; without the macro both read 0.
